// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------------+
// | lsu_pkg: size/state encodings and helpers for the load/store unit          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } lsu_state_e;

  // Bits needed to count up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// +----------------------------------------------------------------------------+
// | lsu_align: byte-lane placement for stores, extraction/extension for loads  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane,
  output logic        st_aligned,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be      = 4'b1111;
    st_lane    = st_data;
    st_aligned = (st_addr_lo == 2'b00);
    case (st_size)
      SZ_B: begin
        st_be      = 4'b0001 << st_addr_lo;
        st_lane    = {4{st_data[7:0]}};
        st_aligned = 1'b1;
      end
      SZ_H: begin
        st_be      = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lane    = {2{st_data[15:0]}};
        st_aligned = ~st_addr_lo[0];
      end
      SZ_W, 2'b11: begin
        st_be      = 4'b1111;
        st_lane    = st_data;
        st_aligned = (st_addr_lo == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_value   = ld_rdata;
    case (ld_size)
      SZ_B:        ld_value = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:        ld_value = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_W, 2'b11: ld_value = ld_rdata;
      default:     ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------------+
// | load_store_unit: memory-stage load/store responder with ready handshake    |
// | Optional: define LSU_TIMEOUT_EN to abort BUS after TIMEOUT_CYCLES waits    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic        stall,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        done_q, done_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;

  logic [3:0]  st_be;
  logic [31:0] st_lane;
  logic        st_aligned;
  logic [31:0] ld_value;
  logic        req;
  logic        in_bus;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  lsu_align u_align (
    .st_addr_lo  (mem_addr[1:0]),
    .st_size     (size),
    .st_data     (store_data),
    .st_be       (st_be),
    .st_lane     (st_lane),
    .st_aligned  (st_aligned),
    .ld_addr_lo  (addr_q[1:0]),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (mem_rdata),
    .ld_value    (ld_value)
  );

  assign req    = load | wr_en;
  assign in_bus = (state_q == ST_BUS);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ld_data_d  = ld_data_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (st_aligned) begin
            // load wins when both are requested, so the op is a store only without load
            state_d = ST_BUS;
            we_d    = ~load;
            addr_d  = mem_addr;
            size_d  = size;
            uns_d   = unsigned_ld;
            wdata_d = load ? 32'h0 : st_lane;
            be_d    = st_be;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (!we_q) ld_data_d = ld_value;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      done_q     <= 1'b0;
      ld_data_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      done_q     <= done_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Bus-side outputs are forced to zero outside BUS so idle/reset shows a quiet bus.
  assign mem_req      = in_bus;
  assign mem_we       = in_bus & we_q;
  assign mem_addr_o   = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata    = in_bus ? wdata_q : 32'h0;
  assign mem_be       = in_bus ? be_q : 4'h0;
  assign stall        = ((state_q == ST_IDLE) & req & st_aligned) | in_bus;
  assign done         = done_q;
  assign ld_data      = ld_data_q;
  assign misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage responder for the ALU's memory outputs (mem_addr, result/store data, load, wr_en). Accepts one load or store per request and performs a ready-handshaked transaction on the data-memory bus. Applies byte-lane alignment and sign/zero extension to load data, and stalls the pipeline until the transaction completes. Sits between the ALU and data memory.

Parameters:
TIMEOUT_CYCLES, 16, max mem_req cycles without mem_ready before abort (used only with LSU_TIMEOUT_EN)

Ports:
One clock; reset is synchronous and active-high.
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
load  input  1  ALU load request
wr_en  input  1  ALU store request
mem_addr  input  32  byte address from ALU
store_data  input  32  store value (rs2)
size  input  2  00 byte, 01 half, 10 word, 11 treated as word
unsigned_ld  input  1  1 = zero-extend load (lbu/lhu)
stall  output  1  hold pipeline (combinational)
done  output  1  1-cycle pulse, transaction complete
ld_data  output  32  aligned/extended load result
misalign_err  output  1  1-cycle pulse, misaligned access rejected
bus_err  output  1  1-cycle pulse, timeout abort (0 when feature off)
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr_o  output  32  {addr[31:2],2'b00}
mem_wdata  output  32  lane-shifted store data
mem_be  output  4  byte enables
mem_ready  input  1  slave accepts/completes this cycle
mem_rdata  input  32  read word, valid when mem_ready

Behaviour:
- Reset: state IDLE; every output 0, including ld_data and mem_be.
- States: IDLE, BUS.
- IDLE: load|wr_en sampled. load has priority if both are high; wr_en is then ignored with no flag. Aligned request: latch addr/size/unsigned/shifted data/be, go to BUS. Misaligned request (half with addr[0]=1, word with addr[1:0]!=0): stay IDLE, misalign_err=1 next cycle, no mem_req, no done, ld_data unchanged.
- BUS: mem_req=1. mem_we, mem_addr_o, mem_wdata and mem_be are registered and held stable until mem_ready. On mem_ready: go to IDLE, done=1 next cycle. On a load, ld_data updates in the same cycle done rises.
- Latency: request in cycle N, mem_req in N+1, mem_ready in N+1 gives done/ld_data in N+2. Each wait cycle adds 1.
- stall = (IDLE & (load|wr_en) & aligned) | BUS. stall is low in the done cycle.
- New requests are ignored while in BUS.
- Store lanes:
  - byte: be=1<<addr[1:0], data replicated in all 4 lanes.
  - half: be=4'b0011 or 4'b1100, data replicated in both halves.
  - word: be=4'b1111.
- Loads:
  - mem_be reflects the accessed lanes.
  - Extract the byte/half at addr[1:0]; sign-extend from bit 7/15 unless unsigned_ld.
  - Word passes through unchanged.
- rst during BUS: next edge returns to IDLE with mem_req=0. The abandoned transaction is dropped, and the slave must tolerate it.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to BUS and increments each BUS cycle without mem_ready. When it reaches TIMEOUT_CYCLES: return to IDLE, bus_err=1 for one cycle, no done, ld_data unchanged.
- Undefined: BUS waits indefinitely, and bus_err is tied 0.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - state encoding ST_IDLE, ST_BUS
  - helper constant for counter width = $clog2(TIMEOUT_CYCLES+1)
- Sub-module lsu_align (combinational):
  - store path: addr[1:0], size, data → be, lane data
  - load path: addr[1:0], size, unsigned, rdata → ld value
- Top holds the FSM, registers and the timeout counter.

Test Plan:
1. sw addr 0x100, data 0xDEADBEEF, mem_ready on first req cycle → mem_req 1 cycle, mem_we=1, be=4'b1111, wdata=0xDEADBEEF, mem_addr_o=0x100, done next cycle, stall 2 cycles.
2. lb addr 0x103, mem_rdata 0x80FF1234 → ld_data 0xFFFFFF80; repeat as lbu → 0x00000080; lh addr 0x102 → 0xFFFF80FF.
3. sh addr 0x102, data 0x0000ABCD, mem_ready delayed 3 cycles → be=4'b1100, wdata=0xABCDABCD held stable 4 req cycles, stall high throughout, single done.
4. lw addr 0x101 → misalign_err pulse, mem_req never asserted, no done, ld_data unchanged.
5. rst asserted on 2nd wait cycle of a lw → mem_req 0 and ld_data 0 after the edge; a following lw completes normally.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready held 0 → bus_err pulse after 8 BUS cycles, back to IDLE, no done.
